// File: rtl/biquad8_coeff_loader.sv
// ---------------------------------------------------------------------------
// biquad8_coeff_loader
//
// Holds a small table of {register, coefficient} pairs and, on request,
// streams the first N entries to a biquad filter block over a Wishbone
// master port. A final write of 1 to word 0 commits the new coefficients.
// Transfers that see wb_err_i, or that wait too long for an ack, abort the
// sequence and raise a sticky error flag.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//   tbl_wr_i/adr/reg/coeff   table write port (accepted only while idle)
//   count_i, start_i         number of entries to send, start pulse
//   busy_o, done_o, err_o    sequence status (done_o is a one-cycle pulse)
//   wb_cyc_o .. wb_sel_o     Wishbone master request (all registered)
//   wb_ack_i, wb_err_i       Wishbone slave response
// ---------------------------------------------------------------------------
module biquad8_coeff_loader #(
    parameter int NENTRY  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        tbl_wr_i,
    input  logic [4:0]  tbl_adr_i,
    input  logic [4:0]  tbl_reg_i,
    input  logic [17:0] tbl_coeff_i,
    input  logic [5:0]  count_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [6:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WRITE  = 3'd2,
        UPDATE = 3'd3,
        ABORT  = 3'd4
    } state_t;

    localparam logic [5:0] N_MAX     = 6'(NENTRY);
    // Last wait-count value at which a transfer is still allowed to finish.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // Table entry layout: {reg[4:0], coeff[17:0]}
    logic [22:0] tbl_mem_r [NENTRY];
    logic [22:0] rd_entry_s;

    state_t      state_r,  state_nxt_s;
    logic [5:0]  idx_r,    idx_nxt_s;
    logic [5:0]  n_r,      n_nxt_s;
    logic [7:0]  wait_r,   wait_nxt_s;
    logic        busy_r,   busy_nxt_s;
    logic        done_r,   done_nxt_s;
    logic        err_r,    err_nxt_s;
    logic        cyc_r,    cyc_nxt_s;
    logic        we_r,     we_nxt_s;
    logic [6:0]  adr_r,    adr_nxt_s;
    logic [31:0] dat_r,    dat_nxt_s;
    logic [3:0]  sel_r,    sel_nxt_s;

    logic [5:0]  idx_inc_s;
    logic        ack_s;
    logic        fail_s;

    // Table write port; contents deliberately survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (tbl_wr_i && !busy_r) begin
            tbl_mem_r[tbl_adr_i] <= {tbl_reg_i, tbl_coeff_i};
        end
    end

    // The FETCH cycle is the read-latency cycle: the entry is captured
    // straight into the registered bus outputs on the FETCH->WRITE edge.
    assign rd_entry_s = tbl_mem_r[idx_r[4:0]];
    assign idx_inc_s  = idx_r + 6'd1;

    // Responses only count while a cycle is open; ack wins over err.
    assign ack_s  = cyc_r & wb_ack_i;
    assign fail_s = cyc_r & ~wb_ack_i & (wb_err_i | (wait_r == WAIT_LAST));

    // State and output registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
            idx_r   <= 6'd0;
            n_r     <= 6'd0;
            wait_r  <= 8'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            cyc_r   <= 1'b0;
            we_r    <= 1'b0;
            adr_r   <= 7'd0;
            dat_r   <= 32'd0;
            sel_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            n_r     <= n_nxt_s;
            wait_r  <= wait_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            cyc_r   <= cyc_nxt_s;
            we_r    <= we_nxt_s;
            adr_r   <= adr_nxt_s;
            dat_r   <= dat_nxt_s;
            sel_r   <= sel_nxt_s;
        end
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        n_nxt_s     = n_r;
        wait_nxt_s  = wait_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = err_r;
        cyc_nxt_s   = cyc_r;
        we_nxt_s    = we_r;
        adr_nxt_s   = adr_r;
        dat_nxt_s   = dat_r;
        sel_nxt_s   = sel_r;

        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if (count_i > N_MAX) begin
                        n_nxt_s = N_MAX;
                    end else begin
                        n_nxt_s = count_i;
                    end
                    err_nxt_s  = 1'b0;
                    idx_nxt_s  = 6'd0;
                    busy_nxt_s = 1'b1;
                    if (count_i == 6'd0) begin
                        state_nxt_s = UPDATE;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            FETCH: begin
                // cyc is low here, which also provides the inter-transfer gap.
                cyc_nxt_s   = 1'b1;
                we_nxt_s    = 1'b1;
                sel_nxt_s   = 4'hF;
                adr_nxt_s   = {rd_entry_s[22:18], 2'b00};
                dat_nxt_s   = {14'd0, rd_entry_s[17:0]};
                wait_nxt_s  = 8'd0;
                state_nxt_s = WRITE;
            end

            WRITE: begin
                if (ack_s) begin
                    cyc_nxt_s = 1'b0;
                    we_nxt_s  = 1'b0;
                    sel_nxt_s = 4'h0;
                    idx_nxt_s = idx_inc_s;
                    if (idx_inc_s < n_r) begin
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = UPDATE;
                    end
                end else if (fail_s) begin
                    cyc_nxt_s   = 1'b0;
                    we_nxt_s    = 1'b0;
                    sel_nxt_s   = 4'h0;
                    state_nxt_s = ABORT;
                end else begin
                    wait_nxt_s = wait_r + 8'd1;
                end
            end

            UPDATE: begin
                // First cycle in UPDATE opens the commit write (cyc was low).
                if (!cyc_r) begin
                    cyc_nxt_s  = 1'b1;
                    we_nxt_s   = 1'b1;
                    sel_nxt_s  = 4'hF;
                    adr_nxt_s  = 7'h00;
                    dat_nxt_s  = 32'h0000_0001;
                    wait_nxt_s = 8'd0;
                end else if (ack_s) begin
                    cyc_nxt_s   = 1'b0;
                    we_nxt_s    = 1'b0;
                    sel_nxt_s   = 4'h0;
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end else if (fail_s) begin
                    cyc_nxt_s   = 1'b0;
                    we_nxt_s    = 1'b0;
                    sel_nxt_s   = 4'h0;
                    state_nxt_s = ABORT;
                end else begin
                    wait_nxt_s = wait_r + 8'd1;
                end
            end

            ABORT: begin
                cyc_nxt_s   = 1'b0;
                we_nxt_s    = 1'b0;
                sel_nxt_s   = 4'h0;
                err_nxt_s   = 1'b1;
                done_nxt_s  = 1'b1;
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end

            default: begin
                cyc_nxt_s   = 1'b0;
                we_nxt_s    = 1'b0;
                sel_nxt_s   = 4'h0;
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign err_o    = err_r;
    assign wb_cyc_o = cyc_r;
    assign wb_stb_o = cyc_r;
    assign wb_we_o  = we_r;
    assign wb_adr_o = adr_r;
    assign wb_dat_o = dat_r;
    assign wb_sel_o = sel_r;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// ---------------------------------------------------------------------------
// Testbench for biquad8_coeff_loader: directed sequences, a Wishbone slave
// model with configurable latency / no-ack / error, and a scoreboard monitor
// that pops expected writes and done pulses as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_biquad8_coeff_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tbl_wr = 1'b0;
    logic [4:0]  tbl_adr = 5'd0;
    logic [4:0]  tbl_reg = 5'd0;
    logic [17:0] tbl_coeff = 18'd0;
    logic [5:0]  count = 6'd0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic        cyc, stb, we;
    logic [6:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack = 1'b0;
    logic        werr = 1'b0;

    biquad8_coeff_loader #(.NENTRY(32), .TIMEOUT(255)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .tbl_wr_i(tbl_wr), .tbl_adr_i(tbl_adr), .tbl_reg_i(tbl_reg),
        .tbl_coeff_i(tbl_coeff), .count_i(count), .start_i(start),
        .busy_o(busy), .done_o(done), .err_o(err),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
        .wb_dat_o(dat), .wb_sel_o(sel), .wb_ack_i(ack), .wb_err_i(werr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [6:0] adr; logic [31:0] dat; } wr_t;
    wr_t exp_wr[$];
    bit  exp_done[$];

    int errors = 0;
    int checks = 0;

    // Slave configuration
    int lat = 3;
    int noack_on = 0;
    int err_on = 0;
    int both_on = 0;
    int xfer_cnt = 0;
    int last_hold = 0;

    // Wishbone slave model: responds lat cycles after stb rises.
    initial begin
        int scnt;
        scnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || !cyc) begin
                ack = 1'b0; werr = 1'b0; scnt = 0;
            end else begin
                if (scnt == 0) xfer_cnt++;
                scnt++;
                if (scnt >= lat && xfer_cnt != noack_on) begin
                    if (xfer_cnt == err_on) werr = 1'b1;
                    else if (xfer_cnt == both_on) begin ack = 1'b1; werr = 1'b1; end
                    else ack = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor: samples on the falling edge.
    initial begin
        bit prev_acc, prev_cyc;
        int hold;
        wr_t e;
        bit  ed;
        prev_acc = 1'b0; prev_cyc = 1'b0; hold = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_acc = 1'b0; prev_cyc = 1'b0; hold = 0;
            end else begin
                if (prev_acc) begin
                    checks++;
                    if (cyc) begin
                        errors++;
                        $display("FAIL gap: cyc=%0b after ack, required 0", cyc);
                    end
                end
                prev_acc = 1'b0;
                if (cyc) hold++;
                else begin
                    if (prev_cyc) last_hold = hold;
                    hold = 0;
                end
                prev_cyc = cyc;
                if (cyc && stb && ack) begin
                    checks++;
                    if (exp_wr.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: adr=%h dat=%h, required none", adr, dat);
                    end else begin
                        e = exp_wr.pop_front();
                        if (adr !== e.adr || dat !== e.dat || we !== 1'b1 || sel !== 4'hF) begin
                            errors++;
                            $display("FAIL write: adr=%h dat=%h we=%b sel=%h, required adr=%h dat=%h we=1 sel=f",
                                     adr, dat, we, sel, e.adr, e.dat);
                        end
                    end
                    prev_acc = 1'b1;
                end
                if (done) begin
                    checks++;
                    if (exp_done.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: done=1 err=%b, required no pulse", err);
                    end else begin
                        ed = exp_done.pop_front();
                        if (err !== ed || busy !== 1'b0) begin
                            errors++;
                            $display("FAIL done_status: err=%b busy=%b, required err=%b busy=0", err, busy, ed);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic load(input int idx, input logic [4:0] r, input logic [17:0] c);
        @(negedge clk);
        tbl_wr = 1'b1; tbl_adr = 5'(idx); tbl_reg = r; tbl_coeff = c;
        @(negedge clk);
        tbl_wr = 1'b0;
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [31:0] d);
        wr_t e;
        e.adr = a; e.dat = d;
        exp_wr.push_back(e);
    endtask

    task automatic start_seq(input logic [5:0] n);
        @(negedge clk);
        count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: %0d writes %0d dones pending after %0d cycles, required 0",
                     nm, exp_wr.size(), exp_done.size(), n);
            exp_wr.delete();
            exp_done.delete();
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({busy, done, err, cyc, stb, we, adr, dat, sel}), 64'd0);
        rst = 1'b0;

        // Three entries, ack after 3 cycles
        load(0, 5'd1, 18'h00123);
        load(1, 5'd2, 18'h3FFFF);
        load(2, 5'd4, 18'h00001);
        push_wr(7'h04, 32'h0000_0123);
        push_wr(7'h08, 32'h0003_FFFF);
        push_wr(7'h10, 32'h0000_0001);
        push_wr(7'h00, 32'h0000_0001);
        exp_done.push_back(1'b0);
        xfer_cnt = 0;
        start_seq(6'd3);
        wait_done("three", 200);
        check("three_err", 64'(err), 64'd0);

        // count 0: commit only; slave answers ack+err together
        push_wr(7'h00, 32'h0000_0001);
        exp_done.push_back(1'b0);
        xfer_cnt = 0; both_on = 1;
        start_seq(6'd0);
        wait_done("zero", 100);
        check("zero_err", 64'(err), 64'd0);
        both_on = 0;

        // Full table, count 40 clamps to 32
        for (int i = 0; i < 32; i++) begin
            load(i, 5'((i * 7 + 3) % 32), 18'((i * 4660 + 5) & 32'h3FFFF));
        end
        for (int i = 0; i < 32; i++) begin
            push_wr(7'(((i * 7 + 3) % 32) * 4), 32'((i * 4660 + 5) & 32'h3FFFF));
        end
        push_wr(7'h00, 32'h0000_0001);
        exp_done.push_back(1'b0);
        xfer_cnt = 0;
        start_seq(6'd40);
        wait_done("full", 1000);

        // Timeout on the 2nd write
        load(0, 5'd1, 18'h00123);
        load(1, 5'd2, 18'h3FFFF);
        push_wr(7'h04, 32'h0000_0123);
        exp_done.push_back(1'b1);
        xfer_cnt = 0; noack_on = 2;
        start_seq(6'd2);
        wait_done("tmo", 2000);
        check("tmo_hold_cycles", 64'(last_hold), 64'd255);
        check("tmo_err", 64'(err), 64'd1);
        noack_on = 0;

        // Bus error on the 1st write, then a clean rerun clears err_o
        exp_done.push_back(1'b1);
        xfer_cnt = 0; err_on = 1;
        start_seq(6'd1);
        wait_done("buserr", 100);
        check("buserr_err", 64'(err), 64'd1);
        err_on = 0;
        push_wr(7'h04, 32'h0000_0123);
        push_wr(7'h00, 32'h0000_0001);
        exp_done.push_back(1'b0);
        xfer_cnt = 0;
        start_seq(6'd1);
        wait_done("rerun", 100);
        check("rerun_err", 64'(err), 64'd0);

        // Reset during WRITE: outputs drop at once, no done pulse
        load(0, 5'd5, 18'h2AAAA);
        lat = 20; xfer_cnt = 0;
        start_seq(6'd1);
        begin
            int n;
            n = 0;
            while (!cyc && n < 20) begin @(negedge clk); n++; end
            check("rst_cyc_seen", 64'(cyc), 64'd1);
        end
        rst = 1'b1;
        #1;
        check("rst_async_cyc_stb_busy", 64'({cyc, stb, busy}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Table survives reset; writes while busy are ignored
        lat = 10;
        push_wr(7'h14, 32'h0002_AAAA);
        push_wr(7'h00, 32'h0000_0001);
        exp_done.push_back(1'b0);
        xfer_cnt = 0;
        start_seq(6'd1);
        @(negedge clk);
        tbl_wr = 1'b1; tbl_adr = 5'd0; tbl_reg = 5'd9; tbl_coeff = 18'h15555;
        repeat (2) @(negedge clk);
        tbl_wr = 1'b0;
        wait_done("busywr1", 200);
        lat = 3;
        push_wr(7'h14, 32'h0002_AAAA);
        push_wr(7'h00, 32'h0000_0001);
        exp_done.push_back(1'b0);
        xfer_cnt = 0;
        start_seq(6'd1);
        wait_done("busywr2", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/biquad8_coeff_loader.md
BIQUAD8_COEFF_LOADER -- requirements
Module: biquad8_coeff_loader

Interface
REQ-001 SHALL have parameter NENTRY, default 32, meaning coefficient table depth (entries).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum wb_clk_i cycles to wait for ack per transfer.
REQ-003 SHALL run on one clock and use an asynchronous, active-high reset, with ports wb_clk_i and wb_rst_i.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: the sole clock.
REQ-005 SHALL have port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port tbl_wr_i, input, 1 bit: table write strobe.
REQ-007 SHALL have port tbl_adr_i, input, 5 bits: table entry index.
REQ-008 SHALL have port tbl_reg_i, input, 5 bits: target biquad word address, which maps to byte address {tbl_reg_i,2'b00}.
REQ-009 SHALL have port tbl_coeff_i, input, 18 bits: coefficient value.
REQ-010 SHALL have port count_i, input, 6 bits: number of entries to send.
REQ-011 SHALL have port start_i, input, 1 bit: start-sequence pulse.
REQ-012 SHALL have port busy_o, output, 1 bit: sequence in progress.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle end-of-sequence pulse.
REQ-014 SHALL have port err_o, output, 1 bit: sticky error flag for the last sequence.
REQ-015 SHALL have Wishbone master outputs wb_cyc_o (1), wb_stb_o (1), wb_we_o (1), wb_adr_o (7), wb_dat_o (32), wb_sel_o (4).
REQ-016 SHALL have Wishbone master inputs wb_ack_i (1) and wb_err_i (1).

Function
REQ-017 SHALL store {tbl_reg_i, tbl_coeff_i} at entry tbl_adr_i on a wb_clk_i edge with tbl_wr_i=1, only while busy_o=0.
REQ-018 SHALL ignore tbl_wr_i while busy_o=1 (table contents unchanged).
REQ-019 SHALL implement FSM states IDLE, FETCH, WRITE, UPDATE and ABORT.
REQ-020 SHALL, in IDLE on start_i=1, latch min(count_i, NENTRY) as N, clear err_o, zero the index, set busy_o=1 on the next cycle, and go to FETCH (or to UPDATE if N=0).
REQ-021 SHALL ignore start_i while busy_o=1.
REQ-022 SHALL read table[index] in FETCH, with exactly one cycle of read latency, then enter WRITE.
REQ-023 SHALL, in WRITE, hold wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=4'hF, wb_adr_o={reg,2'b00} and wb_dat_o={14'b0,coeff}, with all of them stable until ack or error.
REQ-024 SHALL, on wb_ack_i=1 in WRITE, drop cyc/stb on the next cycle and increment the index, then go to FETCH if index<N or to UPDATE otherwise.
REQ-025 SHALL leave at least one idle cycle (cyc=0) between consecutive transfers.
REQ-026 SHALL, in UPDATE, perform one write with wb_adr_o=7'h00 and wb_dat_o=32'h1 using the same handshake, then on ack pulse done_o=1 for one cycle, set busy_o=0 and return to IDLE.
REQ-027 SHALL use an 8-bit wait counter that clears when each transfer begins and increments each cycle cyc is held without ack.
REQ-028 SHALL go to ABORT when the wait counter reaches TIMEOUT or wb_err_i=1 during a transfer.
REQ-029 SHALL, in ABORT, deassert cyc/stb, set err_o=1, pulse done_o, clear busy_o, return to IDLE, and issue no UPDATE write.
REQ-030 SHALL treat wb_ack_i and wb_err_i as ACK if both are asserted in the same cycle.
REQ-031 SHALL ignore wb_ack_i when wb_cyc_o=0.
REQ-032 SHALL hold err_o until the next accepted start_i.

Reset
REQ-033 SHALL, when wb_rst_i=1, immediately force the FSM to IDLE and drive busy_o=0, done_o=0, err_o=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0 and wb_sel_o=0.
REQ-034 SHALL, if reset occurs mid-transfer, abandon the transfer with no done_o pulse.
REQ-035 SHALL NOT clear table contents on reset.

Verification
REQ-036 SHALL cover this scenario: load 3 entries (reg 1/0x00123, reg 2/0x3FFFF, reg 4/0x00001), count_i=3, start; slave acks 3 cycles after stb -> writes to adr 04, 08, 10 with correct data, then adr 00 data 1, one done_o pulse, err_o=0.
REQ-037 SHALL cover this scenario: count_i=0, start -> only the UPDATE write is issued, then done_o.
REQ-038 SHALL cover this scenario: count_i=40, start -> exactly 32 table writes plus the UPDATE write.
REQ-039 SHALL cover this scenario: slave never acks the 2nd write, TIMEOUT=255 -> cyc drops after 255 cycles, err_o=1, done_o pulses, no adr 00 write.
REQ-040 SHALL cover this scenario: wb_err_i during the 1st write -> ABORT; then a second start with a good slave completes and clears err_o.
REQ-041 SHALL cover this scenario: assert wb_rst_i during WRITE -> cyc/stb/busy go to 0 asynchronously with no done_o; tbl_wr_i issued while busy leaves the table unchanged.
